// File: rtl/pkt_cell_pkg.sv
// Shared cell-bus definitions for the TX segmenter and the RX unfolder.
// Field positions inside the cell message and the segmenter FSM states.
package pkt_cell_pkg;

    localparam int DWID_DEF     = 256;
    localparam int FCMWID_DEF   = 50;
    localparam int META_WID_DEF = FCMWID_DEF - 16;

    localparam int ERR_BIT  = 1;
    localparam int EOC_BIT  = 2;
    localparam int SOC_BIT  = 3;
    localparam int VB_LSB   = 4;
    localparam int VB_W     = 6;
    localparam int IDX_LSB  = 10;
    localparam int IDX_W    = 6;
    localparam int META_LSB = 16;

    typedef struct packed {
        logic [META_WID_DEF-1:0] meta;
        logic [IDX_W-1:0]        idx;
        logic [VB_W-1:0]         vbytes;
        logic                    soc;
        logic                    eoc;
        logic                    err;
        logic                    rsvd;
    } cell_msg_t;

    typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;

    // Assembled by bit position so the layout constants stay the single source of truth.
    function automatic cell_msg_t mk_msg(input logic soc, input logic eoc, input logic err,
                                         input logic [VB_W-1:0] vb, input logic [IDX_W-1:0] idx,
                                         input logic [META_WID_DEF-1:0] meta);
        logic [FCMWID_DEF-1:0] v;
        v = '0;
        v[ERR_BIT] = err;
        v[EOC_BIT] = eoc;
        v[SOC_BIT] = soc;
        v[VB_LSB +: VB_W] = vb;
        v[IDX_LSB +: IDX_W] = idx;
        v[META_LSB +: META_WID_DEF] = meta;
        return cell_msg_t'(v);
    endfunction

endpackage

// File: rtl/pkt_cell_seg_if.sv
// Packet-in / cell-out bus of the segmenter.
// Both sides: a transfer happens on a clock edge where vld & rdy are high; the source holds
// its payload stable while vld is high and rdy is low, and never drops vld before the transfer.
interface pkt_cell_seg_if
    import pkt_cell_pkg::*;
#(
    parameter int DWID     = DWID_DEF,
    parameter int FCMWID   = FCMWID_DEF,
    parameter int META_WID = META_WID_DEF
);
    logic                in_vld;
    logic                in_rdy;
    logic [DWID-1:0]     in_dat;
    logic                in_sop;
    logic                in_eop;
    logic [4:0]          in_mty;
    logic [META_WID-1:0] in_meta;
    logic                cell_vld;
    logic                cell_rdy;
    logic [DWID-1:0]     cell_dat;
    logic [FCMWID-1:0]   cell_msg;

    modport master (
        output in_vld, in_dat, in_sop, in_eop, in_mty, in_meta, cell_rdy,
        input  in_rdy, cell_vld, cell_dat, cell_msg
    );

    modport slave (
        input  in_vld, in_dat, in_sop, in_eop, in_mty, in_meta, cell_rdy,
        output in_rdy, cell_vld, cell_dat, cell_msg
    );
endinterface

// File: rtl/pkt_cell_seg_fifo.sv
// Two-entry output FIFO for the segmenter; head is presented directly and reads as zero when empty.
module cell_skid_fifo #(
    parameter int W = 306
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         vld,
    output logic [W-1:0] dat,
    output logic [1:0]   cnt
);
    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   cnt_q;
    logic         pop_eff;

    assign pop_eff = pop & vld;
    assign vld     = (cnt_q != 2'd0);
    assign dat     = vld ? mem[rd_ptr] : '0;
    assign cnt     = cnt_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_eff) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop_eff};
        end
    end
endmodule

// File: rtl/pkt_cell_seg.sv
// TX segmenter: one cell per accepted beat, with framing repair so the cell consumer
// always sees SOC..EOC sequences (abort cells on missing eop, truncation at MAX_CELL).
module pkt_cell_seg
    import pkt_cell_pkg::*;
#(
    parameter int DWID     = DWID_DEF,
    parameter int FCMWID   = FCMWID_DEF,
    parameter int META_WID = META_WID_DEF,
    parameter int MAX_CELL = 64,
    parameter int DBG_WID  = 32
) (
    input  logic               clk,
    input  logic               rst,
    pkt_cell_seg_if.slave      bus,
    output logic [DBG_WID-1:0] dbg_sig
);
    localparam int FW         = DWID + FCMWID;
    localparam int BEAT_BYTES = DWID / 8;

    state_t              state, state_n;
    logic [IDX_W-1:0]    idx, idx_n, nidx;
    logic [META_WID-1:0] meta_q, meta_n;
    logic                pend_vld, pend_vld_n, load_pend;
    logic [DWID-1:0]     pend_dat;
    logic                pend_eop;
    logic [4:0]          pend_mty;
    logic [META_WID-1:0] pend_meta;
    logic [15:0]         pkt_cnt, err_cnt;
    logic                pkt_inc, err_inc;
    logic                in_rdy_q;

    logic                src_go, b_sop, b_eop, trunc;
    logic [DWID-1:0]     b_dat;
    logic [4:0]          b_mty;
    logic [META_WID-1:0] b_meta;
    logic [VB_W-1:0]     b_vb;

    logic                push, pop, f_vld;
    logic [FW-1:0]       push_dat, f_dat;
    logic [1:0]          f_cnt, occ_next;

    cell_skid_fifo #(.W(FW)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .vld      (f_vld),
        .dat      (f_dat),
        .cnt      (f_cnt)
    );

    // Outputs are forced quiet while rst is high, before the synchronous clear lands.
    assign bus.cell_vld = f_vld & ~rst;
    assign {bus.cell_dat, bus.cell_msg} = bus.cell_vld ? f_dat : '0;
    assign pop          = bus.cell_vld & bus.cell_rdy;
    assign bus.in_rdy   = in_rdy_q & ~rst;
    assign dbg_sig      = rst ? '0 : DBG_WID'({err_cnt, pkt_cnt});
    assign occ_next     = f_cnt + {1'b0, push} - {1'b0, pop};

    // A parked beat is always the sop that broke the previous packet; it goes first.
    assign src_go = pend_vld ? (f_cnt != 2'd2) : (bus.in_vld & bus.in_rdy);
    assign b_dat  = pend_vld ? pend_dat  : bus.in_dat;
    assign b_sop  = pend_vld ? 1'b1      : bus.in_sop;
    assign b_eop  = pend_vld ? pend_eop  : bus.in_eop;
    assign b_mty  = pend_vld ? pend_mty  : bus.in_mty;
    assign b_meta = pend_vld ? pend_meta : bus.in_meta;
    assign b_vb   = b_eop ? (VB_W'(BEAT_BYTES) - VB_W'(b_mty)) : VB_W'(BEAT_BYTES);
    assign nidx   = idx + 1'b1;
    assign trunc  = (nidx == IDX_W'(MAX_CELL - 1)) & ~b_eop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            meta_q   <= '0;
            pend_vld <= 1'b0;
            pkt_cnt  <= '0;
            err_cnt  <= '0;
            in_rdy_q <= 1'b1;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            meta_q   <= meta_n;
            pend_vld <= pend_vld_n;
            pkt_cnt  <= pkt_cnt + 16'(pkt_inc);
            err_cnt  <= err_cnt + 16'(err_inc);
            in_rdy_q <= (occ_next <= 2'd1) & ~pend_vld_n;
        end
    end

    always_ff @(posedge clk) begin
        if (load_pend) begin
            pend_dat  <= bus.in_dat;
            pend_eop  <= bus.in_eop;
            pend_mty  <= bus.in_mty;
            pend_meta <= bus.in_meta;
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        meta_n     = meta_q;
        pend_vld_n = pend_vld;
        load_pend  = 1'b0;
        pkt_inc    = 1'b0;
        err_inc    = 1'b0;
        push       = 1'b0;
        push_dat   = '0;
        if (src_go) begin
            pend_vld_n = 1'b0;
            if (state == BODY) begin
                if (b_sop) begin
                    // Close the broken packet with an empty abort cell, replay the sop next cycle.
                    push       = 1'b1;
                    push_dat   = {{DWID{1'b0}}, FCMWID'(mk_msg(1'b0, 1'b1, 1'b1, '0, nidx, meta_q))};
                    load_pend  = 1'b1;
                    pend_vld_n = 1'b1;
                    err_inc    = 1'b1;
                    state_n    = IDLE;
                end else begin
                    push     = 1'b1;
                    push_dat = {b_dat, FCMWID'(mk_msg(1'b0, b_eop | trunc, trunc, b_vb, nidx, meta_q))};
                    idx_n    = nidx;
                    if (b_eop) begin
                        pkt_inc = 1'b1;
                        state_n = IDLE;
                    end else if (trunc) begin
                        pkt_inc = 1'b1;
                        err_inc = 1'b1;
                        state_n = DROP;
                    end
                end
            end else if (b_sop) begin
                push     = 1'b1;
                push_dat = {b_dat, FCMWID'(mk_msg(1'b1, b_eop, 1'b0, b_vb, '0, b_meta))};
                idx_n    = '0;
                meta_n   = b_meta;
                pkt_inc  = b_eop;
                state_n  = b_eop ? IDLE : BODY;
            end else if (state == IDLE) begin
                err_inc = 1'b1;
            end else if (b_eop) begin
                state_n = IDLE;
            end
        end
    end
endmodule

// File: tb/tb_pkt_cell_seg.sv
// Directed bench for pkt_cell_seg: expected cells are queued as beats are driven and
// checked in order as the cell bus transfers them.
module tb_pkt_cell_seg;
    localparam int DW   = 256;
    localparam int FW   = 50;
    localparam int MW   = 34;
    localparam int MAXC = 4;
    localparam int CW   = DW + FW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dbg_sig;

    always #5 clk = ~clk;

    pkt_cell_seg_if #(.DWID(DW), .FCMWID(FW), .META_WID(MW)) bus ();

    pkt_cell_seg #(
        .DWID(DW), .FCMWID(FW), .META_WID(MW), .MAX_CELL(MAXC), .DBG_WID(32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .dbg_sig (dbg_sig)
    );

    int             total = 0;
    int             bad = 0;
    int             rdy_mode = 0;
    int             rdy_low = 0;
    logic [CW-1:0]  exp_q[$];

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic soc, input logic eoc, input logic err,
                                         input logic [5:0] vb, input logic [5:0] idx,
                                         input logic [MW-1:0] meta);
        return {meta, idx, vb, soc, eoc, err, 1'b0};
    endfunction

    function automatic logic [DW-1:0] rand_dat();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (!bus.in_rdy) rdy_low++;
                if (bus.cell_vld && bus.cell_rdy) begin
                    if (exp_q.size() == 0) check("extra_cell_msg", CW'(bus.cell_msg), '0);
                    else check("cell", {bus.cell_dat, bus.cell_msg}, exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic rdy_loop();
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: bus.cell_rdy = 1'b1;
                1: bus.cell_rdy = ~bus.cell_rdy;
                default: bus.cell_rdy = 1'b0;
            endcase
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the edge that took the beat.
    task automatic beat(input logic [DW-1:0] d, input logic sop, input logic eop,
                        input logic [4:0] mty, input logic [MW-1:0] meta);
        logic acc;
        acc = 1'b0;
        bus.in_vld = 1'b1; bus.in_dat = d; bus.in_sop = sop;
        bus.in_eop = eop; bus.in_mty = mty; bus.in_meta = meta;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (bus.in_rdy) begin
                acc = 1'b1;
                break;
            end
        end
        check("beat_accept", CW'(acc), CW'(1));
        @(posedge clk);
        #1;
        bus.in_vld = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("rst_in_rdy", CW'(bus.in_rdy), '0);
        check("rst_cell_vld", CW'(bus.cell_vld), '0);
        check("rst_dbg", CW'(dbg_sig), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_rdy", CW'(bus.in_rdy), CW'(1));
        check("post_rst_cell", {CW'(bus.cell_vld), bus.cell_dat, bus.cell_msg}, '0);
        check("post_rst_dbg", CW'(dbg_sig), '0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int t = 0; t < 200; t++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_left", CW'(exp_q.size()), '0);
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] d0, d1, d2, d3;
        logic [MW-1:0] m1, m2;
        int            low0;
        bus.in_vld = 1'b0; bus.in_dat = '0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
        bus.in_mty = '0; bus.in_meta = '0; bus.cell_rdy = 1'b0;
        fork
            monitor_loop();
            rdy_loop();
        join_none
        @(posedge clk);
        #1;

        // 1: single-beat packet with empty bytes
        rdy_mode = 0;
        reset_dut();
        m1 = 34'h2_AAAA_5555;
        d0 = rand_dat();
        exp_q.push_back({d0, mk(1'b1, 1'b1, 1'b0, 6'd28, 6'd0, m1)});
        beat(d0, 1'b1, 1'b1, 5'd4, m1);
        drain();
        check("t1_dbg", CW'(dbg_sig), CW'(32'h0000_0001));

        // 2: three beats against a toggling cell_rdy
        rdy_mode = 1;
        reset_dut();
        m1 = MW'($urandom);
        low0 = rdy_low;
        d0 = rand_dat(); d1 = rand_dat(); d2 = rand_dat();
        exp_q.push_back({d0, mk(1'b1, 1'b0, 1'b0, 6'd32, 6'd0, m1)});
        exp_q.push_back({d1, mk(1'b0, 1'b0, 1'b0, 6'd32, 6'd1, m1)});
        exp_q.push_back({d2, mk(1'b0, 1'b1, 1'b0, 6'd32, 6'd2, m1)});
        beat(d0, 1'b1, 1'b0, 5'd0, m1);
        beat(d1, 1'b0, 1'b0, 5'd7, MW'($urandom));
        beat(d2, 1'b0, 1'b1, 5'd0, MW'($urandom));
        drain();
        check("t2_in_rdy_dropped", CW'(rdy_low != low0), CW'(1));
        check("t2_dbg", CW'(dbg_sig), CW'(32'h0000_0001));

        // 3: six-beat packet truncated at MAX_CELL
        rdy_mode = 0;
        reset_dut();
        m1 = MW'($urandom);
        for (int i = 0; i < 6; i++) begin
            d0 = rand_dat();
            if (i < MAXC)
                exp_q.push_back({d0, mk(i == 0, i == MAXC - 1, i == MAXC - 1, 6'd32, 6'(i), m1)});
            beat(d0, i == 0, i == 5, 5'd3, m1);
        end
        drain();
        check("t3_dbg", CW'(dbg_sig), CW'(32'h0001_0001));

        // 4: missing eop, sop arrives mid-packet
        reset_dut();
        m1 = MW'($urandom);
        m2 = MW'($urandom);
        d0 = rand_dat(); d1 = rand_dat(); d2 = rand_dat();
        exp_q.push_back({d0, mk(1'b1, 1'b0, 1'b0, 6'd32, 6'd0, m1)});
        exp_q.push_back({d1, mk(1'b0, 1'b0, 1'b0, 6'd32, 6'd1, m1)});
        exp_q.push_back({{DW{1'b0}}, mk(1'b0, 1'b1, 1'b1, 6'd0, 6'd2, m1)});
        exp_q.push_back({d2, mk(1'b1, 1'b1, 1'b0, 6'd32, 6'd0, m2)});
        beat(d0, 1'b1, 1'b0, 5'd0, m1);
        beat(d1, 1'b0, 1'b0, 5'd0, m1);
        beat(d2, 1'b1, 1'b1, 5'd0, m2);
        @(negedge clk);
        check("t4_in_rdy_low", CW'(bus.in_rdy), '0);
        @(negedge clk);
        check("t4_in_rdy_back", CW'(bus.in_rdy), CW'(1));
        @(posedge clk);
        #1;
        drain();
        check("t4_dbg", CW'(dbg_sig), CW'(32'h0001_0001));

        // 5: stray non-sop beat while idle
        reset_dut();
        beat(rand_dat(), 1'b0, 1'b0, 5'd0, MW'($urandom));
        @(negedge clk);
        check("t5_in_rdy", CW'(bus.in_rdy), CW'(1));
        check("t5_no_cell", CW'(bus.cell_vld), '0);
        @(posedge clk);
        #1;
        drain();
        check("t5_dbg", CW'(dbg_sig), CW'(32'h0001_0000));

        // 6: reset mid-packet with the FIFO full
        rdy_mode = 2;
        reset_dut();
        m1 = MW'($urandom);
        beat(rand_dat(), 1'b1, 1'b0, 5'd0, m1);
        beat(rand_dat(), 1'b0, 1'b0, 5'd0, m1);
        @(negedge clk);
        check("t6_full_in_rdy", CW'(bus.in_rdy), '0);
        check("t6_full_vld", CW'(bus.cell_vld), CW'(1));
        @(posedge clk);
        #1;
        reset_dut();
        rdy_mode = 0;
        @(posedge clk);
        #1;
        m2 = MW'($urandom);
        d3 = rand_dat();
        exp_q.push_back({d3, mk(1'b1, 1'b1, 1'b0, 6'd31, 6'd0, m2)});
        beat(d3, 1'b1, 1'b1, 5'd1, m2);
        drain();
        check("t6_dbg", CW'(dbg_sig), CW'(32'h0000_0001));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
